// File: rtl/tpu_pkg.sv
`default_nettype none
// tpu_pkg: shared operand type, feeder state encoding and tile sizing helpers.
// Rev 1.0
package tpu_pkg;

  localparam int DW = 32;

  typedef logic [DW-1:0] word_t;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } feeder_state_t;

  // Cycles needed to push a K-deep tile through the wider edge of the skew.
  function automatic int skew_len(input int k, input int n, input int m);
    return k + ((n > m) ? n : m) - 1;
  endfunction

  function automatic int idx_width(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_feeder_tile_buffer.sv
`default_nettype none
// tile_buffer: K-entry operand store, one beat-wide write port, one read index per lane.
// Rev 1.0
module tile_buffer
  import tpu_pkg::*;
#(
  parameter int W  = 8,
  parameter int K  = 8,
  parameter int IW = idx_width(K)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [IW-1:0]   wr_idx_i,
  input  logic [W*DW-1:0] wr_data_i,
  input  logic [W*IW-1:0] rd_idx_i,
  output logic [W*DW-1:0] rd_data_o
);

  word_t mem_q [K][W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int l = 0; l < W; l++) begin
        mem_q[wr_idx_i][l] <= wr_data_i[l*DW +: DW];
      end
    end
  end

  // Each lane reads its own beat so the skew needs no shift registers.
  for (genvar l = 0; l < W; l++) begin : g_lane
    assign rd_data_o[l*DW +: DW] = mem_q[rd_idx_i[l*IW +: IW]][l];
  end

endmodule
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// systolic_feeder: buffers one K-deep operand tile and replays it diagonally skewed into the array.
// Rev 1.0
module systolic_feeder
  import tpu_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int K      = 8,
  parameter int PE_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_a,
  input  logic [M*DW-1:0] in_b,
  output logic            arr_clr,
  output logic            out_valid,
  output logic [N*DW-1:0] out_a,
  output logic [M*DW-1:0] out_b,
  output logic            res_valid,
  input  logic            res_ready
);

  localparam int T  = skew_len(K, N, M);
  localparam int D  = (N - 1) + (M - 1) + PE_LAT;
  localparam int BW = $clog2(K + 1);
  localparam int CW = $clog2(T + D + 1);
  localparam int IW = idx_width(K);

  feeder_state_t   state_q;
  logic [BW-1:0]   beat_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            arr_clr_q;
  logic            out_valid_q;
  logic            res_valid_q;
  logic [N*DW-1:0] out_a_q;
  logic [M*DW-1:0] out_b_q;

  logic            wr_en;
  logic [CW-1:0]   s_cur;
  logic [N*IW-1:0] a_idx;
  logic [M*IW-1:0] b_idx;
  logic [N*DW-1:0] a_rd;
  logic [M*DW-1:0] b_rd;
  logic [N*DW-1:0] a_stream_d;
  logic [M*DW-1:0] b_stream_d;

  assign wr_en = in_valid && in_ready_q && (state_q == LOAD);

  // Registered outputs lead by one cycle: CLEAR prepares stream cycle 0, STREAM prepares cnt_q.
  assign s_cur = (state_q == CLEAR) ? '0 : cnt_q;

  tile_buffer #(
    .W  (N),
    .K  (K),
    .IW (IW)
  ) u_buf_a (
    .clk       (clk),
    .we_i      (wr_en),
    .wr_idx_i  (beat_q[IW-1:0]),
    .wr_data_i (in_a),
    .rd_idx_i  (a_idx),
    .rd_data_o (a_rd)
  );

  tile_buffer #(
    .W  (M),
    .K  (K),
    .IW (IW)
  ) u_buf_b (
    .clk       (clk),
    .we_i      (wr_en),
    .wr_idx_i  (beat_q[IW-1:0]),
    .wr_data_i (in_b),
    .rd_idx_i  (b_idx),
    .rd_data_o (b_rd)
  );

  for (genvar i = 0; i < N; i++) begin : g_a_lane
    logic [CW-1:0] off;
    logic          live;
    assign off  = s_cur - CW'(i);
    assign live = (s_cur >= CW'(i)) && (off < CW'(K));
    assign a_idx[i*IW +: IW]      = live ? off[IW-1:0] : '0;
    assign a_stream_d[i*DW +: DW] = live ? a_rd[i*DW +: DW] : '0;
  end

  for (genvar j = 0; j < M; j++) begin : g_b_lane
    logic [CW-1:0] off;
    logic          live;
    assign off  = s_cur - CW'(j);
    assign live = (s_cur >= CW'(j)) && (off < CW'(K));
    assign b_idx[j*IW +: IW]      = live ? off[IW-1:0] : '0;
    assign b_stream_d[j*DW +: DW] = live ? b_rd[j*DW +: DW] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      beat_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      arr_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            if (beat_q == BW'(K - 1)) begin
              state_q    <= CLEAR;
              in_ready_q <= 1'b0;
              arr_clr_q  <= 1'b1;
              beat_q     <= '0;
            end else begin
              beat_q <= beat_q + BW'(1);
            end
          end
        end
        CLEAR: begin
          arr_clr_q   <= 1'b0;
          out_valid_q <= 1'b1;
          out_a_q     <= a_stream_d;
          out_b_q     <= b_stream_d;
          cnt_q       <= CW'(1);
          state_q     <= STREAM;
        end
        STREAM: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(T)) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            state_q     <= DRAIN;
          end else begin
            out_a_q <= a_stream_d;
            out_b_q <= b_stream_d;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(T + D)) begin
            cnt_q       <= '0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            beat_q      <= '0;
            state_q     <= LOAD;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign arr_clr   = arr_clr_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign res_valid = res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// tb_systolic_feeder: directed checks of a 2x2/K=3 feeder and an asymmetric 3x2/K=2 feeder.
// Rev 1.0
module tb_systolic_feeder;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst1, iv1, ir1, clr1, ov1, rv1, rr1;
  logic [2*DW-1:0] ia1, ib1, oa1, ob1;
  logic            rst2, iv2, ir2, clr2, ov2, rv2, rr2;
  logic [3*DW-1:0] ia2, oa2;
  logic [2*DW-1:0] ib2, ob2;

  int tests = 0;
  int fails = 0;

  logic [2*DW-1:0] ta1 [3];
  logic [2*DW-1:0] tb1 [3];
  logic [2*DW-1:0] ea1 [4];
  logic [2*DW-1:0] eb1 [4];
  logic [3*DW-1:0] ta2 [2];
  logic [2*DW-1:0] tb2 [2];
  logic [3*DW-1:0] ea2 [4];
  logic [2*DW-1:0] eb2 [4];

  systolic_feeder #(.N(2), .M(2), .K(3), .PE_LAT(1)) u_sq (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_a(ia1), .in_b(ib1),
    .arr_clr(clr1), .out_valid(ov1), .out_a(oa1), .out_b(ob1),
    .res_valid(rv1), .res_ready(rr1)
  );

  systolic_feeder #(.N(3), .M(2), .K(2), .PE_LAT(1)) u_as (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .in_a(ia2), .in_b(ib2),
    .arr_clr(clr2), .out_valid(ov2), .out_a(oa2), .out_b(ob2),
    .res_valid(rv2), .res_ready(rr2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send1(input int gap);
    for (int k = 0; k < 3; k++) begin
      iv1 = 1'b1; ia1 = ta1[k]; ib1 = tb1[k];
      @(negedge clk);
      iv1 = 1'b0;
      if (k < 2) for (int g = 0; g < gap; g++) @(negedge clk);
    end
  endtask

  task automatic stream1(input string nm);
    chk({nm, "_clr"}, clr1, 1);
    chk({nm, "_rdy_clr"}, ir1, 0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("%s_ov_s%0d", nm, s), ov1, 1);
      chk($sformatf("%s_a_s%0d", nm, s), oa1, ea1[s]);
      chk($sformatf("%s_b_s%0d", nm, s), ob1, eb1[s]);
    end
    @(negedge clk);
    chk({nm, "_ov_drain"}, ov1, 0);
    chk({nm, "_a_drain"}, oa1, 0);
    chk({nm, "_b_drain"}, ob1, 0);
    chk({nm, "_rv_d0"}, rv1, 0);
    for (int d = 1; d < 3; d++) begin
      @(negedge clk);
      chk($sformatf("%s_rv_d%0d", nm, d), rv1, 0);
    end
    @(negedge clk);
    chk({nm, "_rv_rise"}, rv1, 1);
  endtask

  task automatic handshake1(input string nm, input int hold);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk($sformatf("%s_rv_hold%0d", nm, c), rv1, 1);
      chk($sformatf("%s_rdy_hold%0d", nm, c), ir1, 0);
    end
    rr1 = 1'b1;
    @(negedge clk);
    rr1 = 1'b0;
    chk({nm, "_rv_clr"}, rv1, 0);
    chk({nm, "_rdy_back"}, ir1, 1);
  endtask

  initial begin
    rst1 = 1'b0; iv1 = 1'b0; rr1 = 1'b0; ia1 = '0; ib1 = '0;
    rst2 = 1'b0; iv2 = 1'b0; rr2 = 1'b0; ia2 = '0; ib2 = '0;

    // Reset held for two edges
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", ir1, 0);
    chk("rst_clr", clr1, 0);
    chk("rst_ov", ov1, 0);
    chk("rst_a", oa1, 0);
    chk("rst_b", ob1, 0);
    chk("rst_rv", rv1, 0);
    chk("rst2_rdy", ir2, 0);
    chk("rst2_ov", ov2, 0);
    chk("rst2_rv", rv2, 0);
    rst1 = 1'b1; rst2 = 1'b1;
    @(negedge clk);
    chk("rel_rdy", ir1, 1);
    chk("rel2_rdy", ir2, 1);

    // Basic 2x2 tile, lane 1 in the upper half of each packed vector
    ta1[0] = {32'd2, 32'd1};  ta1[1] = {32'd4, 32'd3};  ta1[2] = {32'd6, 32'd5};
    tb1[0] = {32'd8, 32'd7};  tb1[1] = {32'd10, 32'd9}; tb1[2] = {32'd12, 32'd11};
    ea1[0] = {32'd0, 32'd1};  ea1[1] = {32'd2, 32'd3};  ea1[2] = {32'd4, 32'd5};  ea1[3] = {32'd6, 32'd0};
    eb1[0] = {32'd0, 32'd7};  eb1[1] = {32'd8, 32'd9};  eb1[2] = {32'd10, 32'd11}; eb1[3] = {32'd12, 32'd0};
    send1(0);
    stream1("basic");
    handshake1("basic", 5);

    // Same tile with two idle cycles between beats
    send1(2);
    stream1("gap");
    handshake1("gap", 0);

    // Abort while stream cycle 2 is on the outputs
    send1(0);
    chk("abort_clr", clr1, 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_a_s2", oa1, {32'd4, 32'd5});
    rst1 = 1'b0;
    @(negedge clk);
    chk("abort_ov", ov1, 0);
    chk("abort_a", oa1, 0);
    chk("abort_b", ob1, 0);
    chk("abort_rdy", ir1, 0);
    chk("abort_rv", rv1, 0);
    rst1 = 1'b1;
    @(negedge clk);
    chk("abort_rdy_back", ir1, 1);
    ta1[0] = {32'd22, 32'd21}; ta1[1] = {32'd24, 32'd23}; ta1[2] = {32'd26, 32'd25};
    tb1[0] = {32'd32, 32'd31}; tb1[1] = {32'd34, 32'd33}; tb1[2] = {32'd36, 32'd35};
    ea1[0] = {32'd0, 32'd21};  ea1[1] = {32'd22, 32'd23}; ea1[2] = {32'd24, 32'd25}; ea1[3] = {32'd26, 32'd0};
    eb1[0] = {32'd0, 32'd31};  eb1[1] = {32'd32, 32'd33}; eb1[2] = {32'd34, 32'd35}; eb1[3] = {32'd36, 32'd0};
    send1(0);
    stream1("retry");
    handshake1("retry", 1);

    // Asymmetric 3x2, K=2: A[i][k] = 0x100+16i+k, B[k][j] = 0x200+16k+j
    ta2[0] = {32'h120, 32'h110, 32'h100};
    ta2[1] = {32'h121, 32'h111, 32'h101};
    tb2[0] = {32'h201, 32'h200};
    tb2[1] = {32'h211, 32'h210};
    ea2[0] = {32'h0,   32'h0,   32'h100};
    ea2[1] = {32'h0,   32'h110, 32'h101};
    ea2[2] = {32'h120, 32'h111, 32'h0};
    ea2[3] = {32'h121, 32'h0,   32'h0};
    eb2[0] = {32'h0,   32'h200};
    eb2[1] = {32'h201, 32'h210};
    eb2[2] = {32'h211, 32'h0};
    eb2[3] = {32'h0,   32'h0};
    for (int k = 0; k < 2; k++) begin
      iv2 = 1'b1; ia2 = ta2[k]; ib2 = tb2[k];
      @(negedge clk);
    end
    iv2 = 1'b0;
    chk("asym_clr", clr2, 1);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("asym_ov_s%0d", s), ov2, 1);
      chk($sformatf("asym_a_s%0d", s), oa2, ea2[s]);
      chk($sformatf("asym_b_s%0d", s), ob2, eb2[s]);
    end
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      chk($sformatf("asym_ov_d%0d", d), ov2, 0);
      chk($sformatf("asym_rv_d%0d", d), rv2, 0);
    end
    @(negedge clk);
    chk("asym_rv_rise", rv2, 1);
    rr2 = 1'b1;
    @(negedge clk);
    rr2 = 1'b0;
    chk("asym_rv_clr", rv2, 0);
    chk("asym_rdy_back", ir2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
